iq_phase_detector: RTL and testbench

Receive-side counterpart to the modulator's NCO and sine table: takes signed 18-bit I/Q sample pairs and recovers the phase in the same 32-bit "turns" format the NCO accumulator uses (2^32 = 2π). It also outputs the instantaneous magnitude and the phase difference from the previous sample. That difference is directly comparable to the NCO `ipFrequency` tuning word. The block is an iterative vectoring CORDIC with valid/ready handshakes, placed after the demodulator front end and feeding carrier/frequency recovery.

---
 rtl/iq_phase_detector.sv | 186 ++++++++++++++++++
 tb/tb_iq_phase_detector.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_phase_detector.sv
// Iterative vectoring CORDIC: signed I/Q sample -> phase (2^32 = one turn), gain-scaled magnitude, phase step.
// Latency: result registers ITERATIONS+2 edges after the accepting edge; one sample in flight at a time.
// Backpressure: opReady only in IDLE; result holds in OUT until ipReady, samples offered while busy are dropped.
module iq_phase_detector #(
    parameter int ITERATIONS = 16
) (
    input  logic               ipClk,
    input  logic               ipReset,
    input  logic signed [17:0] ipI,
    input  logic signed [17:0] ipQ,
    input  logic               ipValid,
    output logic               opReady,
    output logic [31:0]        opPhase,
    output logic [19:0]        opMagnitude,
    output logic [31:0]        opFrequency,
    output logic               opFreqValid,
    output logic               opValid,
    input  logic               ipReady
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRE    = 2'd1,
        S_ROTATE = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    // ROTATE runs micro-rotations for cnt 0..ITERATIONS-1; the step at cnt == ITERATIONS commits the result.
    localparam logic [4:0] LAST_STEP = 5'(ITERATIONS);

    state_t             state_q, state_d;
    logic [4:0]         cnt_q;
    logic signed [20:0] x_q, y_q;
    logic signed [20:0] x_sh, y_sh, x_d, y_d;
    logic [31:0]        z_q, z_d;
    logic [31:0]        atan_val;
    logic [31:0]        result_phase;
    logic               zero_q;
    logic [31:0]        prev_q;
    logic               have_q;
    logic [31:0]        phase_q, freq_q;
    logic [19:0]        mag_q;
    logic               freq_vld_q, out_vld_q;

    // round(atan(2^-i) / 2pi * 2^32)
    function automatic logic [31:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_rom = 32'h2000_0000;
            5'd1:    atan_rom = 32'h12E4_051E;
            5'd2:    atan_rom = 32'h09FB_385B;
            5'd3:    atan_rom = 32'h0511_11D4;
            5'd4:    atan_rom = 32'h028B_0D43;
            5'd5:    atan_rom = 32'h0145_D7E1;
            5'd6:    atan_rom = 32'h00A2_F61E;
            5'd7:    atan_rom = 32'h0051_7C55;
            5'd8:    atan_rom = 32'h0028_BE53;
            5'd9:    atan_rom = 32'h0014_5F2F;
            5'd10:   atan_rom = 32'h000A_2F98;
            5'd11:   atan_rom = 32'h0005_17CC;
            5'd12:   atan_rom = 32'h0002_8BE6;
            5'd13:   atan_rom = 32'h0001_45F3;
            5'd14:   atan_rom = 32'h0000_A2FA;
            5'd15:   atan_rom = 32'h0000_517D;
            5'd16:   atan_rom = 32'h0000_28BE;
            5'd17:   atan_rom = 32'h0000_145F;
            5'd18:   atan_rom = 32'h0000_0A30;
            5'd19:   atan_rom = 32'h0000_0518;
            5'd20:   atan_rom = 32'h0000_028C;
            5'd21:   atan_rom = 32'h0000_0146;
            5'd22:   atan_rom = 32'h0000_00A3;
            5'd23:   atan_rom = 32'h0000_0051;
            default: atan_rom = 32'h0000_0000;
        endcase
    endfunction

    // One micro-rotation driving Y toward zero; both updates use the pre-update X and Y.
    always_comb begin
        atan_val = atan_rom(cnt_q);
        x_sh     = x_q >>> cnt_q;
        y_sh     = y_q >>> cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        if (!y_q[20]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_val;
        end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_val;
        end
    end

    // A zero vector has no angle; report 0 instead of the accumulated table sum.
    assign result_phase = zero_q ? 32'h0000_0000 : z_q;

    // Ready is dropped during the reset cycle itself, whatever state the FSM was in.
    assign opReady     = (state_q == S_IDLE) && !ipReset;
    assign opPhase     = phase_q;
    assign opMagnitude = mag_q;
    assign opFrequency = freq_q;
    assign opFreqValid = freq_vld_q;
    assign opValid     = out_vld_q;

    // FSM state register.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ipValid) state_d = S_PRE;
            S_PRE:    state_d = S_ROTATE;
            S_ROTATE: if (cnt_q == LAST_STEP) state_d = S_OUT;
            S_OUT:    if (ipReady) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: capture, quadrant pre-rotation, micro-rotations, result commit and phase history.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            zero_q     <= 1'b0;
            prev_q     <= '0;
            have_q     <= 1'b0;
            phase_q    <= '0;
            mag_q      <= '0;
            freq_q     <= '0;
            freq_vld_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ipValid) begin
                        // Widen before any negation so -131072 stays representable.
                        x_q    <= {{3{ipI[17]}}, ipI};
                        y_q    <= {{3{ipQ[17]}}, ipQ};
                        zero_q <= (ipI == 18'sd0) && (ipQ == 18'sd0);
                    end
                end
                S_PRE: begin
                    cnt_q <= '0;
                    if (x_q[20]) begin
                        x_q <= -x_q;
                        y_q <= -y_q;
                        z_q <= 32'h8000_0000;
                    end else begin
                        z_q <= 32'h0000_0000;
                    end
                end
                S_ROTATE: begin
                    if (cnt_q != LAST_STEP) begin
                        x_q   <= x_d;
                        y_q   <= y_d;
                        z_q   <= z_d;
                        cnt_q <= cnt_q + 5'd1;
                    end else begin
                        phase_q    <= result_phase;
                        mag_q      <= x_q[19:0];
                        freq_q     <= result_phase - prev_q;
                        freq_vld_q <= have_q;
                        prev_q     <= result_phase;
                        have_q     <= 1'b1;
                        out_vld_q  <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (ipReady) out_vld_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_phase_detector.sv
// Bench for iq_phase_detector: directed table, frequency/wrap sequences, random vectors vs. atan2/sqrt model.
// Latency: checks result appears ITERATIONS+2 edges after acceptance.
// Backpressure: holds ipReady low in OUT and checks stability and that busy-time samples are dropped.
module tb_iq_phase_detector;

    localparam int  ITER  = 16;
    localparam real PI    = 3.14159265358979323846;
    localparam real TWO32 = 4294967296.0;

    logic               ipClk   = 1'b0;
    logic               ipReset = 1'b1;
    logic signed [17:0] ipI     = '0;
    logic signed [17:0] ipQ     = '0;
    logic               ipValid = 1'b0;
    logic               ipReady = 1'b0;
    logic               opReady;
    logic [31:0]        opPhase;
    logic [19:0]        opMagnitude;
    logic [31:0]        opFrequency;
    logic               opFreqValid;
    logic               opValid;

    always #5 ipClk = ~ipClk;

    iq_phase_detector #(.ITERATIONS(ITER)) dut (
        .ipClk       (ipClk),
        .ipReset     (ipReset),
        .ipI         (ipI),
        .ipQ         (ipQ),
        .ipValid     (ipValid),
        .opReady     (opReady),
        .opPhase     (opPhase),
        .opMagnitude (opMagnitude),
        .opFrequency (opFrequency),
        .opFreqValid (opFreqValid),
        .opValid     (opValid),
        .ipReady     (ipReady)
    );

    int          checks = 0;
    int          errors = 0;
    real         gain;
    logic [31:0] mdl_prev;
    bit          mdl_have;
    logic [31:0] last_freq;
    bit          last_fv;

    typedef struct {
        string       name;
        int          i;
        int          q;
        logic [31:0] ph;
        int          ptol;
        int          mag;
        int          mtol;
        bit          chk_mag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input int i, input int q, input logic [31:0] ph,
                                input int ptol, input int mag, input int mtol, input bit chk_mag);
        vec_t v;
        v.name = n; v.i = i; v.q = q; v.ph = ph;
        v.ptol = ptol; v.mag = mag; v.mtol = mtol; v.chk_mag = chk_mag;
        return v;
    endfunction

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit phase_near(input logic [31:0] a, input logic [31:0] e, input int tol);
        logic [31:0] d;
        int          sd;
        d  = a - e;
        sd = $signed(d);
        return (sd <= tol) && (sd >= -tol);
    endfunction

    // Exact angle of the input vector in turns scaled to 2^32.
    function automatic logic [31:0] ref_phase(input int i, input int q);
        real t;
        if (i == 0 && q == 0) return 32'h0;
        t = $atan2(real'(q), real'(i)) / (2.0 * PI) * TWO32;
        if (t < 0.0) t = t + TWO32;
        return 32'(longint'(t));
    endfunction

    function automatic int ref_mag(input int i, input int q);
        real r;
        r = gain * $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
        return int'(r);
    endfunction

    function automatic int iq_of(input real amp, input logic [31:0] w, input bit want_q);
        real th;
        th = real'(w) / TWO32 * 2.0 * PI;
        return want_q ? int'(amp * $sin(th)) : int'(amp * $cos(th));
    endfunction

    task automatic send_in(input int i, input int q);
        int n;
        n = 0;
        while (!opReady && n < 100) begin
            @(posedge ipClk); #1;
            n++;
        end
        check("accept_ready", opReady, opReady, 1);
        ipI     = 18'(i);
        ipQ     = 18'(q);
        ipValid = 1'b1;
        @(posedge ipClk); #1;
        ipValid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!opValid && lat < 100) begin
            @(posedge ipClk); #1;
            lat++;
        end
        check("valid_timeout", opValid, opValid, 1);
    endtask

    task automatic ack();
        ipReady = 1'b1;
        @(posedge ipClk); #1;
        ipReady = 1'b0;
    endtask

    // Compare the current output against the model, then advance the model's phase history.
    task automatic judge(input string name, input int i, input int q, input logic [31:0] eph,
                         input int ptol, input int emag, input int mtol, input bit chk_mag);
        logic [31:0] efreq;
        int          dm;
        check({name, "_phase"}, phase_near(opPhase, eph, ptol), opPhase, eph);
        if (chk_mag) begin
            dm = int'(opMagnitude) - emag;
            check({name, "_mag"}, (dm <= mtol) && (dm >= -mtol), opMagnitude, emag);
        end
        check({name, "_freqvalid"}, opFreqValid == mdl_have, opFreqValid, mdl_have);
        if (mdl_have) begin
            efreq = ref_phase(i, q) - mdl_prev;
            check({name, "_freq"}, phase_near(opFrequency, efreq, 131072), opFrequency, efreq);
        end
        last_freq = opFrequency;
        last_fv   = opFreqValid;
        mdl_prev  = ref_phase(i, q);
        mdl_have  = 1'b1;
    endtask

    task automatic process(input string name, input int i, input int q, input logic [31:0] eph,
                           input int ptol, input int emag, input int mtol, input bit chk_mag);
        int lat;
        send_in(i, q);
        wait_out(lat);
        check({name, "_latency"}, lat == ITER + 2, lat, ITER + 2);
        judge(name, i, q, eph, ptol, emag, mtol, chk_mag);
        ack();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        real         p;
        int          i, q, lat, a;
        logic [31:0] w, ph0, fr0;
        logic [19:0] mg0;
        logic        fv0;

        gain = 1.0;
        p    = 1.0;
        for (int j = 0; j < ITER; j++) begin
            gain = gain * $sqrt(1.0 + p);
            p    = p / 4.0;
        end
        mdl_prev = 32'h0;
        mdl_have = 1'b0;

        vecs.push_back(mk("card0",     100000,       0, 32'h0000_0000, 65536, 164676, 16, 1));
        vecs.push_back(mk("card90",         0,  100000, 32'h4000_0000, 65536, 164676, 16, 1));
        vecs.push_back(mk("card270",        0, -100000, 32'hC000_0000, 65536, 164676, 16, 1));
        vecs.push_back(mk("card180",  -100000,       0, 32'h8000_0000, 65536, 164676, 16, 1));
        vecs.push_back(mk("negfs",    -131072,       0, 32'h8000_0000, 65536, 215844, 16, 1));
        vecs.push_back(mk("negdiag",  -131072, -131072, 32'hA000_0000, 65536,      0,  0, 0));
        vecs.push_back(mk("posdiag",   131071,  131071, 32'h2000_0000, 65536,      0,  0, 0));
        vecs.push_back(mk("zero",           0,       0, 32'h0000_0000,     0,      0,  0, 1));

        // Reset state, sampled while reset is still asserted.
        repeat (3) @(posedge ipClk);
        #1;
        check("rst_ready",    opReady == 1'b0,       opReady,     0);
        check("rst_valid",    opValid == 1'b0,       opValid,     0);
        check("rst_phase",    opPhase == 32'h0,      opPhase,     0);
        check("rst_mag",      opMagnitude == 20'h0,  opMagnitude, 0);
        check("rst_freq",     opFrequency == 32'h0,  opFrequency, 0);
        check("rst_freqvld",  opFreqValid == 1'b0,   opFreqValid, 0);
        ipReset = 1'b0;
        #1;
        check("post_rst_ready", opReady == 1'b1, opReady, 1);

        // Rotating carrier: first result has no frequency, later ones step by 0x0100_0000.
        for (int k = 0; k < 20; k++) begin
            w = 32'(k) * 32'h0100_0000;
            i = iq_of(120000.0, w, 1'b0);
            q = iq_of(120000.0, w, 1'b1);
            process("freqrec", i, q, ref_phase(i, q), 65536, ref_mag(i, q), 16, 1);
            if (k == 0) check("freqrec_first_fv", last_fv == 1'b0, last_fv, 0);
            else check("freqrec_step", phase_near(last_freq, 32'h0100_0000, 131072), last_freq, 32'h0100_0000);
        end

        foreach (vecs[n])
            process(vecs[n].name, vecs[n].i, vecs[n].q, vecs[n].ph, vecs[n].ptol,
                    vecs[n].mag, vecs[n].mtol, vecs[n].chk_mag);

        // Phase wrap: the step across zero must come out as a small positive difference.
        i = iq_of(120000.0, 32'hF800_0000, 1'b0);
        q = iq_of(120000.0, 32'hF800_0000, 1'b1);
        process("wrap_a", i, q, 32'hF800_0000, 65536, ref_mag(i, q), 16, 1);
        i = iq_of(120000.0, 32'h0800_0000, 1'b0);
        q = iq_of(120000.0, 32'h0800_0000, 1'b1);
        process("wrap_b", i, q, 32'h0800_0000, 65536, ref_mag(i, q), 16, 1);
        check("wrap_freq", phase_near(last_freq, 32'h1000_0000, 131072), last_freq, 32'h1000_0000);
        check("wrap_fv", last_fv == 1'b1, last_fv, 1);

        for (int n = 0; n < 30; n++) begin
            a = int'($urandom_range(125000, 60000));
            w = $urandom;
            i = iq_of(real'(a), w, 1'b0);
            q = iq_of(real'(a), w, 1'b1);
            process("rand", i, q, ref_phase(i, q), 65536, ref_mag(i, q), 16, 1);
        end

        // Backpressure: result must hold and a sample offered meanwhile must be ignored.
        send_in(70000, -40000);
        wait_out(lat);
        check("bp_latency", lat == ITER + 2, lat, ITER + 2);
        ph0 = opPhase; mg0 = opMagnitude; fr0 = opFrequency; fv0 = opFreqValid;
        judge("bp", 70000, -40000, ref_phase(70000, -40000), 65536, ref_mag(70000, -40000), 16, 1);
        ipI = 18'sd5000; ipQ = 18'sd5000; ipValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge ipClk); #1;
            check("bp_hold", opValid && opPhase == ph0 && opMagnitude == mg0 &&
                  opFrequency == fr0 && opFreqValid == fv0, opPhase, ph0);
            check("bp_ready_low", opReady == 1'b0, opReady, 0);
        end
        ipValid = 1'b0;
        ack();
        check("bp_release_valid", opValid == 1'b0, opValid, 0);
        check("bp_release_ready", opReady == 1'b1, opReady, 1);
        process("bp_next", 30000, 90000, ref_phase(30000, 90000), 65536, ref_mag(30000, 90000), 16, 1);

        // Reset during micro-rotation 7 aborts the sample and forgets phase history.
        send_in(100000, 50000);
        repeat (8) @(posedge ipClk);
        #1;
        ipReset = 1'b1;
        @(posedge ipClk); #1;
        check("midrst_valid", opValid == 1'b0,      opValid,     0);
        check("midrst_ready", opReady == 1'b0,      opReady,     0);
        check("midrst_phase", opPhase == 32'h0,     opPhase,     0);
        check("midrst_mag",   opMagnitude == 20'h0, opMagnitude, 0);
        check("midrst_freq",  opFrequency == 32'h0, opFrequency, 0);
        ipReset  = 1'b0;
        mdl_have = 1'b0;
        mdl_prev = 32'h0;
        #1;
        check("midrst_ready_after", opReady == 1'b1, opReady, 1);
        process("post_rst", 90000, 30000, ref_phase(90000, 30000), 65536, ref_mag(90000, 30000), 16, 1);
        check("post_rst_fv", last_fv == 1'b0, last_fv, 0);

        // Zero vector: exact zero outputs, and it still becomes the previous phase.
        process("zero2", 0, 0, 32'h0, 0, 0, 0, 1);
        process("after_zero", 0, 100000, 32'h4000_0000, 65536, 164676, 16, 1);
        check("after_zero_freq", phase_near(last_freq, 32'h4000_0000, 131072), last_freq, 32'h4000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
